otp_read_sequencer: RTL and testbench

- Read-side counterpart of the OTP programming controller. Sequences the bit-line, plate-line and word-line drivers to read one column of the A×B OTP array row by row.
- Samples the sense-amplifier output for each row and returns the A-bit word with a one-cycle valid pulse.
- Shares the array driver encodings with the write controller; a top-level mux selects between the two.

---
 rtl/otp_read_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_otp_read_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/otp_read_sequencer.sv
// otp_read_sequencer: drives BL/PL/WL lines to read one column of an A x B OTP array, one row at a time.
// Latency: data_valid rises 4 + A*(SETTLE_CYCLES+3) edges after read_req is accepted
//          (4 + A*(SETTLE_CYCLES+4) with OTP_READ_DOUBLE_SAMPLE_EN).
// Backpressure: none; read_req is sampled only in IDLE and ignored while a read is in flight.
// Ports: clk/reset_n (async active-low); read_req + column start a read; sense_in is the sense-amp bit;
//        PL/BL/WLN/WLP/PRG are array driver codes; data_out/data_valid return the word;
//        read_active marks array activity; read_error flags a rejected column or a sample mismatch.
// Optional macro: OTP_READ_DOUBLE_SAMPLE_EN adds a second sample per row with a mismatch check.
module otp_read_sequencer #(
    parameter int A             = 2,
    parameter int B             = 2,
    parameter int ADDR_WIDTH    = $clog2(B),
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read_req,
    input  logic [ADDR_WIDTH-1:0] column,
    input  logic                  sense_in,
    output logic [2*B-1:0]        PL,
    output logic [B-1:0]          BL,
    output logic [A-1:0]          WLN,
    output logic [A-1:0]          WLP,
    output logic                  PRG,
    output logic [A-1:0]          data_out,
    output logic                  data_valid,
    output logic                  read_active,
    output logic                  read_error
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("otp_read_sequencer: SETTLE_CYCLES must be >= 1");
    end
    if (A < 1 || B < 2) begin : g_bad_geom
        $error("otp_read_sequencer: need A >= 1 and B >= 2");
    end

    localparam int ROW_W = (A > 1) ? $clog2(A) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ROW_W-1:0]      ROW_LAST    = ROW_W'(A - 1);
    localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    // One extra bit so the range check works even when B is not a power of two.
    localparam logic [ADDR_WIDTH:0]   B_LIM       = (ADDR_WIDTH + 1)'(B);

    typedef enum logic [3:0] {
        S_IDLE, S_PREP_BL, S_PREP_PL, S_SELECT, S_SETTLE, S_SAMPLE,
        S_SAMPLE2, S_DESELECT, S_PD_PL, S_PD_BL, S_DONE
    } state_t;

    state_t                state_q, state_nxt;
    logic [ADDR_WIDTH-1:0] col_q, col_nxt;
    logic [ROW_W-1:0]      row_q, row_nxt;
    logic [CNT_W-1:0]      settle_q, settle_nxt;
    logic [A-1:0]          cap_q, cap_nxt;
    logic [2*B-1:0]        pl_nxt;
    logic [B-1:0]          bl_nxt;
    logic [A-1:0]          wln_nxt;
    logic [A-1:0]          dout_nxt;
    logic                  dv_nxt, act_nxt, err_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            settle_q    <= '0;
            cap_q       <= '0;
            PL          <= '0;
            BL          <= '0;
            WLN         <= '1;
            WLP         <= '1;
            PRG         <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            read_active <= 1'b0;
            read_error  <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            col_q       <= col_nxt;
            row_q       <= row_nxt;
            settle_q    <= settle_nxt;
            cap_q       <= cap_nxt;
            PL          <= pl_nxt;
            BL          <= bl_nxt;
            WLN         <= wln_nxt;
            WLP         <= '1;      // read path never drives the HIGH word-line level
            PRG         <= 1'b0;
            data_out    <= dout_nxt;
            data_valid  <= dv_nxt;
            read_active <= act_nxt;
            read_error  <= err_nxt;
        end
    end

    // Every output is registered, so each "entry edge" action is computed here
    // in the state that precedes it.
    always_comb begin
        state_nxt  = state_q;
        col_nxt    = col_q;
        row_nxt    = row_q;
        settle_nxt = settle_q;
        cap_nxt    = cap_q;
        pl_nxt     = PL;
        bl_nxt     = BL;
        wln_nxt    = WLN;
        dout_nxt   = data_out;
        dv_nxt     = 1'b0;
        act_nxt    = read_active;
        err_nxt    = read_error;
        case (state_q)
            S_IDLE: begin
                if (read_req) begin
                    if ({1'b0, column} < B_LIM) begin
                        col_nxt        = column;
                        row_nxt        = '0;
                        err_nxt        = 1'b0;
                        bl_nxt         = '0;
                        bl_nxt[column] = 1'b1;
                        act_nxt        = 1'b1;
                        state_nxt      = S_PREP_BL;
                    end else begin
                        // Out-of-range column: answer immediately with an error, data_out untouched.
                        dv_nxt  = 1'b1;
                        err_nxt = 1'b1;
                    end
                end
            end
            S_PREP_BL: begin
                pl_nxt                 = '0;
                pl_nxt[2*col_q +: 2]   = 2'b10;
                state_nxt              = S_PREP_PL;
            end
            S_PREP_PL: begin
                wln_nxt        = '1;
                wln_nxt[row_q] = 1'b0;
                state_nxt      = S_SELECT;
            end
            S_SELECT: begin
                settle_nxt = '0;
                state_nxt  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_nxt = S_SAMPLE;
                end else begin
                    settle_nxt = settle_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                cap_nxt[row_q] = sense_in;
`ifdef OTP_READ_DOUBLE_SAMPLE_EN
                state_nxt      = S_SAMPLE2;
`else
                wln_nxt[row_q] = 1'b1;
                state_nxt      = S_DESELECT;
`endif
            end
`ifdef OTP_READ_DOUBLE_SAMPLE_EN
            S_SAMPLE2: begin
                // cap_q already holds the first sample; the first sample wins on mismatch.
                if (sense_in != cap_q[row_q]) begin
                    err_nxt = 1'b1;
                end
                wln_nxt[row_q] = 1'b1;
                state_nxt      = S_DESELECT;
            end
`endif
            S_DESELECT: begin
                if (row_q == ROW_LAST) begin
                    pl_nxt    = '0;
                    state_nxt = S_PD_PL;
                end else begin
                    row_nxt          = row_q + 1'b1;
                    wln_nxt          = '1;
                    wln_nxt[row_nxt] = 1'b0;
                    state_nxt        = S_SELECT;
                end
            end
            S_PD_PL: begin
                bl_nxt    = '0;
                state_nxt = S_PD_BL;
            end
            S_PD_BL: begin
                dout_nxt  = cap_q;
                dv_nxt    = 1'b1;
                act_nxt   = 1'b0;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_otp_read_sequencer.sv
module tb_otp_read_sequencer;

    localparam int A  = 2;
    localparam int B  = 2;
    localparam int AW = 1;
`ifdef OTP_READ_DOUBLE_SAMPLE_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 14;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          read_req = 1'b0;
    logic [AW-1:0] column = '0;
    logic          sense_in = 1'b0;
    logic [2*B-1:0] PL;
    logic [B-1:0]  BL;
    logic [A-1:0]  WLN, WLP;
    logic          PRG;
    logic [A-1:0]  data_out;
    logic          data_valid, read_active, read_error;

    int total = 0;
    int bad   = 0;

    otp_read_sequencer #(.A(A), .B(B), .ADDR_WIDTH(AW), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .read_req(read_req), .column(column),
        .sense_in(sense_in), .PL(PL), .BL(BL), .WLN(WLN), .WLP(WLP), .PRG(PRG),
        .data_out(data_out), .data_valid(data_valid), .read_active(read_active),
        .read_error(read_error)
    );

    always #5 clk = ~clk;

    // Expected per-edge values for a column-1 read, index k = edges after acceptance edge E0.
    logic [1:0] exp_wln [16] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01,
                                 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [1:0] exp_bl  [16] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [3:0] exp_pl  [16] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [15:0] exp_act = 16'b0011_1111_1111_1111;
    logic [15:0] exp_dv  = 16'b0100_0000_0000_0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        read_req = 1'b1;
        column   = 1'b1;
        sense_in = 1'b1;
        step();
        read_req = 1'b0;
        repeat ($urandom_range(1, 10)) step();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++; if (BL !== 2'b00) begin bad++; $display("FAIL rst_bl got=%b want=00", BL); end
        total++; if (PL !== 4'b0000) begin bad++; $display("FAIL rst_pl got=%b want=0000", PL); end
        total++; if (WLN !== 2'b11) begin bad++; $display("FAIL rst_wln got=%b want=11", WLN); end
        total++; if (WLP !== 2'b11) begin bad++; $display("FAIL rst_wlp got=%b want=11", WLP); end
        total++; if (PRG !== 1'b0) begin bad++; $display("FAIL rst_prg got=%b want=0", PRG); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rst_dv got=%b want=0", data_valid); end
        total++; if (read_active !== 1'b0) begin bad++; $display("FAIL rst_act got=%b want=0", read_active); end
        total++; if (data_out !== 2'b00) begin bad++; $display("FAIL rst_dout got=%b want=00", data_out); end
        total++; if (read_error !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", read_error); end
        step();
        reset_n = 1'b1;
        step();
    endtask

    // Column-1 read, row0 senses 1 and row1 senses 0. With inject set, a request
    // for column 0 is presented at edge 5 and must be ignored.
    task automatic run_read_col1(input bit inject);
        sense_in = 1'b1;
        read_req = 1'b1;
        column   = 1'b1;
        step();
        read_req = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step();
            total++; if (WLN !== exp_wln[k]) begin bad++; $display("FAIL rd_wln k=%0d got=%b want=%b", k, WLN, exp_wln[k]); end
            total++; if (BL !== exp_bl[k]) begin bad++; $display("FAIL rd_bl k=%0d got=%b want=%b", k, BL, exp_bl[k]); end
            total++; if (PL !== exp_pl[k]) begin bad++; $display("FAIL rd_pl k=%0d got=%b want=%b", k, PL, exp_pl[k]); end
            total++; if (read_active !== exp_act[k]) begin bad++; $display("FAIL rd_act k=%0d got=%b want=%b", k, read_active, exp_act[k]); end
            total++; if (data_valid !== exp_dv[k]) begin bad++; $display("FAIL rd_dv k=%0d got=%b want=%b", k, data_valid, exp_dv[k]); end
            total++; if (WLP !== 2'b11 || PRG !== 1'b0) begin bad++; $display("FAIL rd_wlp_prg k=%0d got=%b/%b want=11/0", k, WLP, PRG); end
            if (k >= 14) begin
                total++; if (data_out !== 2'b01) begin bad++; $display("FAIL rd_dout k=%0d got=%b want=01", k, data_out); end
                total++; if (read_error !== 1'b0) begin bad++; $display("FAIL rd_err k=%0d got=%b want=0", k, read_error); end
            end
            if (k == 6) sense_in = 1'b0;
            if (inject && k == 4) begin read_req = 1'b1; column = 1'b0; end
            if (inject && k == 5) read_req = 1'b0;
        end
    endtask

    task automatic test_read_col1();
        run_read_col1(1'b0);
    endtask

    task automatic test_busy_ignore();
        run_read_col1(1'b1);
    endtask

    task automatic test_reset_mid_read();
        int got;
        read_req = 1'b1;
        column   = 1'b0;
        sense_in = 1'b0;
        step();
        read_req = 1'b0;
        repeat (8) step();
        total++; if (WLN !== 2'b01 || read_active !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b/%b want=01/1", WLN, read_active); end
        reset_n = 1'b0;
        #1;
        total++; if (BL !== 2'b00 || PL !== 4'b0000) begin bad++; $display("FAIL mid_rst_blpl got=%b/%b want=00/0000", BL, PL); end
        total++; if (WLN !== 2'b11 || read_active !== 1'b0) begin bad++; $display("FAIL mid_rst_wln got=%b/%b want=11/0", WLN, read_active); end
        for (int i = 0; i < 3; i++) begin
            total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_dv i=%0d got=%b want=0", i, data_valid); end
            step();
        end
        reset_n = 1'b1;
        step();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL mid_rel_dv got=%b want=0", data_valid); end
        // Fresh read of column 0: row0 senses 0, row1 senses 1.
        got = -1;
        read_req = 1'b1;
        column   = 1'b0;
        sense_in = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (n == 0) read_req = 1'b0;
            if (n == 1) begin
                total++; if (BL !== 2'b01 || PL !== 4'b0010) begin bad++; $display("FAIL mid_c0_lines got=%b/%b want=01/0010", BL, PL); end
            end
            if (n == 7) sense_in = 1'b1;
            if (data_valid) begin got = n; break; end
        end
        total++; if (got !== LAT) begin bad++; $display("FAIL mid_lat got=%0d want=%0d", got, LAT); end
        total++; if (data_out !== 2'b10) begin bad++; $display("FAIL mid_dout got=%b want=10", data_out); end
        total++; if (read_error !== 1'b0) begin bad++; $display("FAIL mid_err got=%b want=0", read_error); end
        step();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL mid_dv_pulse got=%b want=0", data_valid); end
    endtask

`ifdef OTP_READ_DOUBLE_SAMPLE_EN
    task automatic test_double_sample();
        int got;
        got = -1;
        sense_in = 1'b1;
        read_req = 1'b1;
        column   = 1'b1;
        for (int n = 0; n < 40; n++) begin
            step();
            if (n == 0) read_req = 1'b0;
            if (n == 6) sense_in = 1'b0;
            if (data_valid) begin got = n; break; end
        end
        total++; if (got !== 16) begin bad++; $display("FAIL ds_lat got=%0d want=16", got); end
        total++; if (read_error !== 1'b1) begin bad++; $display("FAIL ds_err got=%b want=1", read_error); end
        total++; if (data_out !== 2'b01) begin bad++; $display("FAIL ds_dout got=%b want=01", data_out); end
        step();
    endtask
`endif

    task automatic test_back_to_back();
        int v1, v2;
        v1 = -1;
        v2 = -1;
        sense_in = 1'b0;
        read_req = 1'b1;
        column   = 1'b1;
        for (int n = 0; n < 60; n++) begin
            step();
            if (data_valid) begin
                if (v1 < 0) v1 = n;
                else begin v2 = n; break; end
            end
        end
        read_req = 1'b0;
        total++; if (v1 !== LAT) begin bad++; $display("FAIL b2b_first got=%0d want=%0d", v1, LAT); end
        total++; if (v2 - v1 !== LAT + 2) begin bad++; $display("FAIL b2b_gap got=%0d want=%0d", v2 - v1, LAT + 2); end
        total++; if (data_out !== 2'b00) begin bad++; $display("FAIL b2b_dout got=%b want=00", data_out); end
        step();
        step();
        total++; if (read_active !== 1'b0 || data_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b/%b want=0/0", read_active, data_valid); end
    endtask

    initial begin
        test_reset();
`ifdef OTP_READ_DOUBLE_SAMPLE_EN
        test_double_sample();
`else
        test_read_col1();
        test_busy_ignore();
`endif
        test_reset_mid_read();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
